// File: rtl/ssm_pkg.sv
// Shared definitions for the SSM tile engine: scheduler states, sizing helpers
// and the default model dimensions.
package ssm_pkg;

  localparam int SSM_H  = 24;
  localparam int SSM_P  = 64;
  localparam int SSM_N  = 16;
  localparam int SSM_DW = 16;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_WRITE = 3'd4,
    S_DONE  = 3'd5,
    S_ERR   = 3'd6
  } ssm_state_e;

  function automatic int ssm_clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Never returns zero so single-valued ranges still get a 1-bit field.
  function automatic int ssm_width(input int v);
    return (ssm_clog2(v) < 1) ? 1 : ssm_clog2(v);
  endfunction

endpackage

// File: rtl/ssm_tile_counter.sv
// Two-level tile walker: p_base is the inner loop, h_base steps when p_base wraps.
module ssm_tile_counter
  import ssm_pkg::*;
#(
  parameter int H      = SSM_H,
  parameter int P      = SSM_P,
  parameter int H_TILE = 3,
  parameter int P_TILE = 2,
  parameter int HW     = ssm_width(H),
  parameter int PW     = ssm_width(P)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          adv,
  output logic [HW-1:0] h_base,
  output logic [PW-1:0] p_base,
  output logic          last
);

  localparam logic [HW-1:0] H_STEP = HW'(H_TILE);
  localparam logic [PW-1:0] P_STEP = PW'(P_TILE);
  localparam logic [HW-1:0] H_LAST = HW'(H - H_TILE);
  localparam logic [PW-1:0] P_LAST = PW'(P - P_TILE);

  logic p_wrap;

  assign p_wrap = (p_base == P_LAST);
  assign last   = p_wrap && (h_base == H_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_base <= '0;
      p_base <= '0;
    end else if (clr) begin
      h_base <= '0;
      p_base <= '0;
    end else if (adv) begin
      if (p_wrap) begin
        p_base <= '0;
        h_base <= h_base + H_STEP;
      end else begin
        p_base <= p_base + P_STEP;
      end
    end
  end

endmodule

// File: rtl/ssm_tile_scheduler.sv
// Walks the H x P output space tile by tile: load, launch, wait (with watchdog),
// write back. Strobes are decoded from the state register only.
module ssm_tile_scheduler
  import ssm_pkg::*;
#(
  parameter int H       = SSM_H,
  parameter int P       = SSM_P,
  parameter int H_TILE  = 3,
  parameter int P_TILE  = 2,
  parameter int TIMEOUT = 1024,
  localparam int HW     = ssm_width(H),
  localparam int PW     = ssm_width(P),
  localparam int NT     = (H / H_TILE) * (P / P_TILE),
  localparam int TW     = ssm_width(NT + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          ld_en,
  output logic          tile_start,
  input  logic          tile_done,
  output logic [HW-1:0] tile_h_base,
  output logic [PW-1:0] tile_p_base,
  output logic          y_wr_en,
  output logic [TW-1:0] tile_idx,
  output ssm_state_e    dbg_state
);

  localparam int WDW = ssm_width(TIMEOUT);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

  if (((H % H_TILE) != 0) || ((P % P_TILE) != 0)) begin : g_bad_tiling
    $error("ssm_tile_scheduler: H/P must be multiples of H_TILE/P_TILE");
  end

  ssm_state_e     state, state_next;
  logic [WDW-1:0] wd_cnt;
  logic           start_ok;
  logic           last;
  logic           adv;

  assign start_ok  = start && ((state == S_IDLE) || (state == S_ERR));
  assign adv       = (state == S_WRITE) && !last;
  assign dbg_state = state;

  ssm_tile_counter #(
    .H      (H),
    .P      (P),
    .H_TILE (H_TILE),
    .P_TILE (P_TILE),
    .HW     (HW),
    .PW     (PW)
  ) u_counter (
    .clk    (clk),
    .rst    (rst),
    .clr    (start_ok),
    .adv    (adv),
    .h_base (tile_h_base),
    .p_base (tile_p_base),
    .last   (last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Completion is checked before expiry so a tile_done on the last watchdog cycle wins.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_ERR: if (start) state_next = S_LOAD;
      S_LOAD:        state_next = S_ISSUE;
      S_ISSUE:       state_next = S_WAIT;
      S_WAIT: begin
        if (tile_done)              state_next = S_WRITE;
        else if (wd_cnt == WD_LAST) state_next = S_ERR;
      end
      S_WRITE:       state_next = last ? S_DONE : S_LOAD;
      S_DONE:        state_next = S_IDLE;
      default:       state_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy       = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    ld_en      = 1'b0;
    tile_start = 1'b0;
    y_wr_en    = 1'b0;
    case (state)
      S_LOAD:  begin busy = 1'b1; ld_en      = 1'b1; end
      S_ISSUE: begin busy = 1'b1; tile_start = 1'b1; end
      S_WAIT:  busy = 1'b1;
      S_WRITE: begin busy = 1'b1; y_wr_en    = 1'b1; end
      S_DONE:  begin busy = 1'b1; done       = 1'b1; end
      S_ERR:   err = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                wd_cnt <= '0;
    else if (state == S_ISSUE)              wd_cnt <= '0;
    else if ((state == S_WAIT) && !tile_done) wd_cnt <= wd_cnt + WDW'(1);
  end

  // tile_idx counts every written tile, so it reads NT once the run completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    tile_idx <= '0;
    else if (start_ok)          tile_idx <= '0;
    else if (state == S_WRITE)  tile_idx <= tile_idx + TW'(1);
  end

endmodule

// File: tb/tb_ssm_tile_scheduler.sv
// Directed bench for ssm_tile_scheduler: three instances (default dims, small
// dims with TIMEOUT=16, small dims with TIMEOUT=8) driven by a shared engine model.
module tb_ssm_tile_scheduler;
  import ssm_pkg::*;

  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] start_v;
  logic [2:0] tile_done_v;
  logic [2:0] busy_v, done_v, err_v, ld_en_v, tile_start_v, y_wr_en_v;
  logic [4:0] h_a;
  logic [5:0] p_a;
  logic [8:0] idx_a;
  logic [2:0] h_b, h_c;
  logic [1:0] p_b, p_c;
  logic [2:0] idx_b, idx_c;
  ssm_state_e st_a, st_b, st_c;

  int n_tests = 0;
  int n_fail  = 0;
  int  eng_k[3];
  int  eng_cnt[3];
  bit  eng_en[3];
  bit  eng_rand[3];
  bit  eng_inj[3];

  ssm_tile_scheduler u_dut_a (
    .clk(clk), .rst(rst), .start(start_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .err(err_v[0]), .ld_en(ld_en_v[0]), .tile_start(tile_start_v[0]),
    .tile_done(tile_done_v[0]), .tile_h_base(h_a), .tile_p_base(p_a),
    .y_wr_en(y_wr_en_v[0]), .tile_idx(idx_a), .dbg_state(st_a)
  );

  ssm_tile_scheduler #(.H(6), .P(4), .H_TILE(3), .P_TILE(2), .TIMEOUT(16)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .err(err_v[1]), .ld_en(ld_en_v[1]), .tile_start(tile_start_v[1]),
    .tile_done(tile_done_v[1]), .tile_h_base(h_b), .tile_p_base(p_b),
    .y_wr_en(y_wr_en_v[1]), .tile_idx(idx_b), .dbg_state(st_b)
  );

  ssm_tile_scheduler #(.H(6), .P(4), .H_TILE(3), .P_TILE(2), .TIMEOUT(8)) u_dut_c (
    .clk(clk), .rst(rst), .start(start_v[2]), .busy(busy_v[2]), .done(done_v[2]),
    .err(err_v[2]), .ld_en(ld_en_v[2]), .tile_start(tile_start_v[2]),
    .tile_done(tile_done_v[2]), .tile_h_base(h_c), .tile_p_base(p_c),
    .y_wr_en(y_wr_en_v[2]), .tile_idx(idx_c), .dbg_state(st_c)
  );

  // Engine model: answers k cycles after tile_start; optionally injects stray
  // tile_done pulses in LOAD/ISSUE/WRITE.
  initial begin
    logic [2:0] td;
    tile_done_v = '0;
    for (int g = 0; g < 3; g++) eng_cnt[g] = 0;
    forever begin
      @(negedge clk);
      td = '0;
      for (int g = 0; g < 3; g++) begin
        if (rst) begin
          eng_cnt[g] = 0;
        end else begin
          if (eng_cnt[g] > 0) begin
            eng_cnt[g]--;
            if (eng_cnt[g] == 0) td[g] = 1'b1;
          end
          if (tile_start_v[g] && eng_en[g])
            eng_cnt[g] = eng_rand[g] ? int'($urandom_range(20, 1)) : eng_k[g];
          if (eng_inj[g] && (ld_en_v[g] || tile_start_v[g] || y_wr_en_v[g]) &&
              ($urandom_range(1, 0) == 1))
            td[g] = 1'b1;
        end
      end
      tile_done_v = td;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int cur_h(input int g);
    case (g)
      0:       return int'(h_a);
      1:       return int'(h_b);
      default: return int'(h_c);
    endcase
  endfunction

  function automatic int cur_p(input int g);
    case (g)
      0:       return int'(p_a);
      1:       return int'(p_b);
      default: return int'(p_c);
    endcase
  endfunction

  function automatic int cur_idx(input int g);
    case (g)
      0:       return int'(idx_a);
      1:       return int'(idx_b);
      default: return int'(idx_c);
    endcase
  endfunction

  // Called at a negedge; returns at the negedge of cycle 1 (LOAD).
  task automatic pulse_start(input int g);
    start_v[g] = 1'b1;
    @(negedge clk);
    start_v[g] = 1'b0;
  endtask

  // Runs one full sequence on instance g, checking every write-back against a
  // nested-loop model. Cycle 1 is the LOAD cycle after the accepting edge.
  task automatic run_tiles(input int g, input int np, input int ht, input int pt,
                           input int budget, input bit noisy,
                           output int writes, output int dones, output int done_cyc,
                           output int n_ld, output int n_ts);
    int eh, ep, ei, cyc;
    bit fin;
    eh = 0; ep = 0; ei = 0;
    writes = 0; dones = 0; done_cyc = 0; n_ld = 0; n_ts = 0;
    fin = 1'b0;
    pulse_start(g);
    cyc = 1;
    check("go_busy", 32'(busy_v[g]), 32'd1);
    check("go_err", 32'(err_v[g]), 32'd0);
    while (!fin && cyc <= budget) begin
      if (ld_en_v[g]) n_ld++;
      if (tile_start_v[g]) n_ts++;
      if (y_wr_en_v[g]) begin
        check("wr_h", 32'(cur_h(g)), 32'(eh));
        check("wr_p", 32'(cur_p(g)), 32'(ep));
        check("wr_idx", 32'(cur_idx(g)), 32'(ei));
        writes++;
        ei++;
        ep += pt;
        if (ep >= np) begin
          ep = 0;
          eh += ht;
        end
      end
      if (done_v[g]) begin
        dones++;
        done_cyc = cyc;
        check("done_busy", 32'(busy_v[g]), 32'd1);
        check("done_err", 32'(err_v[g]), 32'd0);
      end else if (dones > 0) begin
        check("post_busy", 32'(busy_v[g]), 32'd0);
        fin = 1'b1;
      end
      start_v[g] = (noisy && !fin && busy_v[g] && !done_v[g]) ? 1'($urandom_range(1, 0)) : 1'b0;
      if (!fin) begin
        @(negedge clk);
        cyc++;
      end
    end
    start_v[g] = 1'b0;
    check("run_finished", 32'(fin), 32'd1);
  endtask

  initial begin
    int w, d, dc, nl, nts, wcnt, nd, nw;
    start_v = '0;
    for (int g = 0; g < 3; g++) begin
      eng_en[g] = 1'b1; eng_rand[g] = 1'b0; eng_inj[g] = 1'b0; eng_k[g] = 4;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_busy", 32'(busy_v), 32'd0);
    check("rst_done", 32'(done_v), 32'd0);
    check("rst_err", 32'(err_v), 32'd0);
    check("rst_strobes", 32'(ld_en_v | tile_start_v | y_wr_en_v), 32'd0);
    check("rst_bases_a", 32'({h_a, p_a}), 32'd0);
    check("rst_idx_a", 32'(idx_a), 32'd0);
    check("rst_state_a", 32'(st_a), 32'(S_IDLE));
    rst = 1'b0;
    @(negedge clk);

    // 1: default dimensions, k=4 -> 256 tiles, done at cycle 1+256*7
    eng_k[0] = 4;
    run_tiles(0, 64, 3, 2, 3000, 1'b0, w, d, dc, nl, nts);
    check("t1_writes", 32'(w), 32'd256);
    check("t1_dones", 32'(d), 32'd1);
    check("t1_done_cyc", 32'(dc), 32'd1793);
    check("t1_loads", 32'(nl), 32'd256);

    // 2: 6x4 space, k=1 -> 4 tiles of 4 cycles
    eng_k[1] = 1;
    run_tiles(1, 4, 3, 2, 100, 1'b0, w, d, dc, nl, nts);
    check("t2_writes", 32'(w), 32'd4);
    check("t2_loads", 32'(nl), 32'd4);
    check("t2_starts", 32'(nts), 32'd4);
    check("t2_done_cyc", 32'(dc), 32'd17);

    // 3: silent engine, TIMEOUT=16: WAIT spans cycles 3..18, ERR from cycle 19
    eng_en[1] = 1'b0;
    pulse_start(1);
    nd = 0; nw = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (cyc == 18) begin
        check("t3_wait_busy", 32'(busy_v[1]), 32'd1);
        check("t3_wait_err", 32'(err_v[1]), 32'd0);
      end
      if (cyc == 19) begin
        check("t3_err", 32'(err_v[1]), 32'd1);
        check("t3_err_busy", 32'(busy_v[1]), 32'd0);
      end
      if (done_v[1]) nd++;
      if (y_wr_en_v[1]) nw++;
      @(negedge clk);
    end
    check("t3_no_done", 32'(nd), 32'd0);
    check("t3_no_write", 32'(nw), 32'd0);
    check("t3_err_sticky", 32'(err_v[1]), 32'd1);
    eng_en[1] = 1'b1;
    run_tiles(1, 4, 3, 2, 100, 1'b0, w, d, dc, nl, nts);
    check("t3_rerun_writes", 32'(w), 32'd4);
    check("t3_rerun_err", 32'(err_v[1]), 32'd0);

    // 4: random k, stray starts and stray tile_done pulses
    eng_rand[0] = 1'b1;
    eng_inj[0]  = 1'b1;
    run_tiles(0, 64, 3, 2, 8000, 1'b1, w, d, dc, nl, nts);
    check("t4_writes", 32'(w), 32'd256);
    check("t4_dones", 32'(d), 32'd1);
    eng_rand[0] = 1'b0;
    eng_inj[0]  = 1'b0;

    // 5: reset during the WAIT of tile 5 (bases 0,10)
    eng_k[0] = 4;
    pulse_start(0);
    wcnt = 0;
    while (!(st_a == S_WAIT && idx_a == 9'd5) && wcnt < 200) begin
      @(negedge clk);
      wcnt++;
    end
    check("t5_reached", 32'(wcnt < 200), 32'd1);
    check("t5_bases", 32'({h_a, p_a}), 32'({5'd0, 6'd10}));
    rst = 1'b1;
    #1;
    check("t5_rst_busy", 32'(busy_v[0]), 32'd0);
    check("t5_rst_strobes", 32'({ld_en_v[0], tile_start_v[0], y_wr_en_v[0], done_v[0]}), 32'd0);
    check("t5_rst_idx", 32'(idx_a), 32'd0);
    check("t5_rst_bases", 32'({h_a, p_a}), 32'd0);
    check("t5_rst_state", 32'(st_a), 32'(S_IDLE));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_tiles(0, 64, 3, 2, 3000, 1'b0, w, d, dc, nl, nts);
    check("t5_writes", 32'(w), 32'd256);
    check("t5_done_cyc", 32'(dc), 32'd1793);

    // 6: tile_done lands on the expiring watchdog cycle (TIMEOUT=8, k=8)
    eng_k[2] = 8;
    run_tiles(2, 4, 3, 2, 200, 1'b0, w, d, dc, nl, nts);
    check("t6_writes", 32'(w), 32'd4);
    check("t6_done_cyc", 32'(dc), 32'd45);
    check("t6_err", 32'(err_v[2]), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
